// File: rtl/subtracter_pkg.sv
// Shared types and sizing helpers for the multicycle subtracter.
package subtracter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultChunk = 4;

    function automatic int unsigned calc_nchunk(int unsigned width, int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int unsigned calc_idx_width(int unsigned nchunk);
        return (nchunk > 32'd1) ? int'($clog2(nchunk)) : 32'd1;
    endfunction

endpackage

// File: rtl/multicycle_subtracter_if.sv
// Operand and result handshakes of the multicycle subtracter.
interface multicycle_subtracter_if
    import subtracter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             lent;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_minus_b;
    logic             borrowed_bit;
    logic             zero;

    modport master (
        output in_valid, a, b, lent, out_ready,
        input  in_ready, out_valid, a_minus_b, borrowed_bit, zero
    );

    modport slave (
        input  in_valid, a, b, lent, out_ready,
        output in_ready, out_valid, a_minus_b, borrowed_bit, zero
    );

endinterface

// File: rtl/chunk_subtracter.sv
// CHUNK-bit combinational ripple of full subtracters.
module chunk_subtracter #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             lent,
    output logic [CHUNK-1:0] a_minus_b,
    output logic             borrowed_bit
);

    logic [CHUNK:0] brw;

    always_comb begin
        brw       = '0;
        a_minus_b = '0;
        brw[0]    = lent;
        for (int i = 0; i < int'(CHUNK); i++) begin
            a_minus_b[i] = a[i] ^ b[i] ^ brw[i];
            brw[i+1]     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
        borrowed_bit = brw[CHUNK];
    end

endmodule

// File: rtl/multicycle_subtracter.sv
// Unsigned a - b - lent, one CHUNK-bit slice per clock, valid/ready on both sides.
// Define SUBTRACTER_SATURATE_EN to clamp underflowing results to zero.
module multicycle_subtracter
    import subtracter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_subtracter_if.slave bus
);

    localparam int unsigned NChunk = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IdxW   = calc_idx_width(NChunk);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic             borrowed_q, borrowed_d;
    logic             zero_q, zero_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_borrow;
    logic             last_chunk;

    assign base       = 32'(idx_q) * CHUNK;
    assign chunk_a    = a_q[base +: CHUNK];
    assign chunk_b    = b_q[base +: CHUNK];
    assign last_chunk = (idx_q == IdxW'(NChunk - 1));

    chunk_subtracter #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a            (chunk_a),
        .b            (chunk_b),
        .lent         (brw_q),
        .a_minus_b    (chunk_diff),
        .borrowed_bit (chunk_borrow)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        part_d     = part_q;
        res_d      = res_q;
        brw_d      = brw_q;
        borrowed_d = borrowed_q;
        zero_d     = zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.lent;
                    idx_d   = '0;
                    part_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                part_d[base +: CHUNK] = chunk_diff;
                brw_d                 = chunk_borrow;
                if (last_chunk) begin
                    // Output registers see only the complete result.
                    res_d      = part_d;
                    borrowed_d = chunk_borrow;
                    zero_d     = (part_d == '0);
`ifdef SUBTRACTER_SATURATE_EN
                    if (chunk_borrow) begin
                        res_d  = '0;
                        zero_d = 1'b1;
                    end
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            part_q     <= '0;
            res_q      <= '0;
            brw_q      <= 1'b0;
            borrowed_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            part_q     <= part_d;
            res_q      <= res_d;
            brw_q      <= brw_d;
            borrowed_q <= borrowed_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle) && !rst;
    assign bus.out_valid    = (state_q == StDone);
    assign bus.a_minus_b    = res_q;
    assign bus.borrowed_bit = borrowed_q;
    assign bus.zero         = zero_q;

endmodule

// File: tb/tb_multicycle_subtracter.sv
// Directed bench for multicycle_subtracter (CHUNK=4 and CHUNK=16 instances).
module tb_multicycle_subtracter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_subtracter_if #(.WIDTH(16)) mif ();
    multicycle_subtracter_if #(.WIDTH(16)) wif ();

    multicycle_subtracter #(.WIDTH(16), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    multicycle_subtracter #(.WIDTH(16), .CHUNK(16)) dut_wide (
        .clk (clk),
        .rst (rst),
        .bus (wif)
    );

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic l);
        int n;
        n = 0;
        while (!mif.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        mif.in_valid = 1'b1;
        mif.a        = a;
        mif.b        = b;
        mif.lent     = l;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!mif.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        mif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        mif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        #2;
        checks++; if (mif.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready got %b want 0", mif.in_ready); end
        checks++; if (mif.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", mif.out_valid); end
        checks++; if ({mif.a_minus_b, mif.borrowed_bit, mif.zero} !== 18'h0) begin errors++;
            $display("FAIL reset_outputs got %h/%b/%b want 0/0/0",
                     mif.a_minus_b, mif.borrowed_bit, mif.zero); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mif.in_ready !== 1'b1) begin errors++;
            $display("FAIL release_in_ready got %b want 1", mif.in_ready); end
        // Park a result in DONE, then reset asynchronously mid-cycle.
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done(lat);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b0) begin errors++;
            $display("FAIL async_reset_hs got valid=%b ready=%b want 0/0",
                     mif.out_valid, mif.in_ready); end
        checks++; if ({mif.a_minus_b, mif.borrowed_bit, mif.zero} !== 18'h0) begin errors++;
            $display("FAIL async_reset_outputs got %h/%b/%b want 0/0/0",
                     mif.a_minus_b, mif.borrowed_bit, mif.zero); end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mif.in_ready !== 1'b1) begin errors++;
            $display("FAIL async_release_in_ready got %b want 1", mif.in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done(lat);
        checks++; if (lat != 4) begin errors++;
            $display("FAIL basic_latency got %0d want 4", lat); end
        checks++; if (mif.a_minus_b !== 16'h1000) begin errors++;
            $display("FAIL basic_result got %h want 1000", mif.a_minus_b); end
        checks++; if (mif.borrowed_bit !== 1'b0 || mif.zero !== 1'b0) begin errors++;
            $display("FAIL basic_flags got b=%b z=%b want 0/0", mif.borrowed_bit, mif.zero); end
        pop();
        checks++; if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1) begin errors++;
            $display("FAIL basic_pop got valid=%b ready=%b want 0/1",
                     mif.out_valid, mif.in_ready); end
    endtask

    task automatic test_underflow();
        int lat;
        logic [15:0] exp_res;
        logic        exp_zero;
`ifdef SUBTRACTER_SATURATE_EN
        exp_res  = 16'h0000;
        exp_zero = 1'b1;
`else
        exp_res  = 16'hFFFF;
        exp_zero = 1'b0;
`endif
        start_op(16'h0000, 16'h0001, 1'b0);
        wait_done(lat);
        checks++; if (mif.a_minus_b !== exp_res) begin errors++;
            $display("FAIL underflow_result got %h want %h", mif.a_minus_b, exp_res); end
        checks++; if (mif.borrowed_bit !== 1'b1 || mif.zero !== exp_zero) begin errors++;
            $display("FAIL underflow_flags got b=%b z=%b want 1/%b",
                     mif.borrowed_bit, mif.zero, exp_zero); end
        pop();
    endtask

    task automatic test_vectors();
        logic [15:0] va [4] = '{16'h0005, 16'h1000, 16'hABCD, 16'h0003};
        logic [15:0] vb [4] = '{16'h0004, 16'h0001, 16'h1234, 16'h0003};
        logic        vl [4] = '{1'b1,     1'b0,     1'b0,     1'b1};
        logic [15:0] vr [4] = '{16'h0000, 16'h0FFF, 16'h9999, 16'hFFFF};
        logic        vbo[4] = '{1'b0,     1'b0,     1'b0,     1'b1};
        logic        vz [4] = '{1'b1,     1'b0,     1'b0,     1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vl[i]);
            wait_done(lat);
`ifdef SUBTRACTER_SATURATE_EN
            if (vbo[i]) begin
                vr[i] = 16'h0000;
                vz[i] = 1'b1;
            end
`endif
            checks++; if (mif.a_minus_b !== vr[i]) begin errors++;
                $display("FAIL vec%0d_result got %h want %h", i, mif.a_minus_b, vr[i]); end
            checks++; if (mif.borrowed_bit !== vbo[i] || mif.zero !== vz[i]) begin errors++;
                $display("FAIL vec%0d_flags got b=%b z=%b want %b/%b",
                         i, mif.borrowed_bit, mif.zero, vbo[i], vz[i]); end
            pop();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        start_op(16'h8000, 16'h0001, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 3; i++) begin
            mif.in_valid = 1'b1;
            mif.a        = 16'hFFFF;
            mif.b        = 16'h0000;
            mif.lent     = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (mif.out_valid !== 1'b1 || mif.in_ready !== 1'b0 ||
                mif.a_minus_b !== 16'h7FFF || mif.borrowed_bit !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d got v=%b r=%b res=%h b=%b want 1/0/7fff/0",
                         i, mif.out_valid, mif.in_ready, mif.a_minus_b, mif.borrowed_bit);
            end
        end
        mif.in_valid = 1'b0;
        pop();
        checks++; if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1) begin errors++;
            $display("FAIL stall_release got valid=%b ready=%b want 0/1",
                     mif.out_valid, mif.in_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (mif.out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++;
            $display("FAIL stall_no_accept got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        start_op(16'h1234, 16'h0234, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mif.out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++;
            $display("FAIL midrun_reset got %0d valid cycles want 0", seen); end
        start_op(16'h0005, 16'h0004, 1'b1);
        wait_done(lat);
        checks++; if (lat != 4 || mif.a_minus_b !== 16'h0000 || mif.zero !== 1'b1 ||
                      mif.borrowed_bit !== 1'b0) begin errors++;
            $display("FAIL midrun_fresh got lat=%0d res=%h z=%b b=%b want 4/0000/1/0",
                     lat, mif.a_minus_b, mif.zero, mif.borrowed_bit); end
        pop();
    endtask

    task automatic test_one_cycle();
        int lat;
        wif.in_valid = 1'b1;
        wif.a        = 16'h1234;
        wif.b        = 16'h0234;
        wif.lent     = 1'b0;
        @(posedge clk);
        #1;
        wif.in_valid = 1'b0;
        lat = 0;
        while (!wif.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat != 1) begin errors++;
            $display("FAIL wide_latency got %0d want 1", lat); end
        checks++; if (wif.a_minus_b !== 16'h1000 || wif.borrowed_bit !== 1'b0 ||
                      wif.zero !== 1'b0) begin errors++;
            $display("FAIL wide_result got %h/%b/%b want 1000/0/0",
                     wif.a_minus_b, wif.borrowed_bit, wif.zero); end
        wif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        wif.out_ready = 1'b0;
        checks++; if (wif.out_valid !== 1'b0 || wif.in_ready !== 1'b1) begin errors++;
            $display("FAIL wide_pop got valid=%b ready=%b want 0/1",
                     wif.out_valid, wif.in_ready); end
    endtask

    initial begin
        mif.in_valid  = 1'b0;
        mif.a         = '0;
        mif.b         = '0;
        mif.lent      = 1'b0;
        mif.out_ready = 1'b0;
        wif.in_valid  = 1'b0;
        wif.a         = '0;
        wif.b         = '0;
        wif.lent      = 1'b0;
        wif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_one_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
